// File: rtl/morra_pkg.sv
// Shared encodings and constants for the rock-paper-scissors referee.
// The move, round-result and match-result codes all live here.
package morra_pkg;

    localparam int unsigned MIN_MANCHE = 4;
    localparam int unsigned MAX_EXTRA  = 15;

    typedef enum logic [1:0] {
        MOVE_NONE     = 2'b00,
        MOVE_ROCK     = 2'b01,
        MOVE_PAPER    = 2'b10,
        MOVE_SCISSORS = 2'b11
    } move_e;

    typedef enum logic [1:0] {
        MANCHE_NONE = 2'b00,
        MANCHE_P1   = 2'b01,
        MANCHE_P2   = 2'b10,
        MANCHE_TIE  = 2'b11
    } manche_e;

    typedef enum logic [1:0] {
        PARTITA_NONE = 2'b00,
        PARTITA_P1   = 2'b01,
        PARTITA_P2   = 2'b10,
        PARTITA_DRAW = 2'b11
    } partita_e;

    typedef enum logic {
        IDLE = 1'b0,
        PLAY = 1'b1
    } state_e;

    // True when move a defeats move b. Both moves must be valid.
    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == MOVE_ROCK     && b == MOVE_SCISSORS) ||
               (a == MOVE_SCISSORS && b == MOVE_PAPER)    ||
               (a == MOVE_PAPER    && b == MOVE_ROCK);
    endfunction

endpackage

// File: rtl/morra_judge.sv
// Combinational judge for a single round.
// Returns no-round whenever either player gave no move.
module morra_judge
    import morra_pkg::*;
(
    input  logic [1:0] primo_i,
    input  logic [1:0] secondo_i,
    output logic [1:0] manche_o
);

    always_comb begin
        manche_o = MANCHE_NONE;
        if (primo_i != MOVE_NONE && secondo_i != MOVE_NONE) begin
            if (primo_i == secondo_i) begin
                manche_o = MANCHE_TIE;
            end else if (beats(primo_i, secondo_i)) begin
                manche_o = MANCHE_P1;
            end else begin
                manche_o = MANCHE_P2;
            end
        end
    end

endmodule

// File: rtl/morra_cinese.sv
// Rock-paper-scissors match referee: one round per clock, registered
// round and match results, configurable round limit loaded at start.
module morra_cinese
    import morra_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       INIZIO,
    input  logic [1:0] PRIMO,
    input  logic [1:0] SECONDO,
    output logic [1:0] MANCHE,
    output logic [1:0] PARTITA
);

    localparam logic [4:0] MIN_MANCHE_W = 5'(MIN_MANCHE);
    localparam logic [4:0] MAX_EXTRA_W  = 5'(MAX_EXTRA);

    state_e     state_q, state_d;
    logic [4:0] played_q, played_d;
    logic [4:0] wins1_q, wins1_d;
    logic [4:0] wins2_q, wins2_d;
    logic [4:0] max_q, max_d;
    logic       restr_valid_q, restr_valid_d;
    logic       restr_p2_q, restr_p2_d;
    logic [1:0] restr_move_q, restr_move_d;
    logic [1:0] manche_q, manche_d;
    logic [1:0] partita_q, partita_d;

    logic [1:0] round_res;
    logic       repeat_block;
    logic       round_valid;
    logic [4:0] played_nxt, wins1_nxt, wins2_nxt, diff_nxt;
    logic       match_end;

    morra_judge u_judge (
        .primo_i   (PRIMO),
        .secondo_i (SECONDO),
        .manche_o  (round_res)
    );

    // Last round's winner may not reuse the move he just won with.
    assign repeat_block = restr_valid_q &&
                          ((!restr_p2_q && PRIMO   == restr_move_q) ||
                           ( restr_p2_q && SECONDO == restr_move_q));
    assign round_valid  = (round_res != MANCHE_NONE) && !repeat_block;

    assign played_nxt = played_q + 5'd1;
    assign wins1_nxt  = wins1_q + 5'(round_res == MANCHE_P1);
    assign wins2_nxt  = wins2_q + 5'(round_res == MANCHE_P2);
    assign diff_nxt   = (wins1_nxt >= wins2_nxt) ? (wins1_nxt - wins2_nxt)
                                                 : (wins2_nxt - wins1_nxt);
    assign match_end  = ((played_nxt >= MIN_MANCHE_W) && (diff_nxt >= 5'd2)) ||
                        (played_nxt == max_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            played_q      <= '0;
            wins1_q       <= '0;
            wins2_q       <= '0;
            max_q         <= '0;
            restr_valid_q <= 1'b0;
            restr_p2_q    <= 1'b0;
            restr_move_q  <= '0;
            manche_q      <= MANCHE_NONE;
            partita_q     <= PARTITA_NONE;
        end else begin
            state_q       <= state_d;
            played_q      <= played_d;
            wins1_q       <= wins1_d;
            wins2_q       <= wins2_d;
            max_q         <= max_d;
            restr_valid_q <= restr_valid_d;
            restr_p2_q    <= restr_p2_d;
            restr_move_q  <= restr_move_d;
            manche_q      <= manche_d;
            partita_q     <= partita_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        played_d      = played_q;
        wins1_d       = wins1_q;
        wins2_d       = wins2_q;
        max_d         = max_q;
        restr_valid_d = restr_valid_q;
        restr_p2_d    = restr_p2_q;
        restr_move_d  = restr_move_q;
        if (INIZIO) begin
            state_d       = PLAY;
            played_d      = '0;
            wins1_d       = '0;
            wins2_d       = '0;
            max_d         = MIN_MANCHE_W + (5'({PRIMO, SECONDO}) & MAX_EXTRA_W);
            restr_valid_d = 1'b0;
        end else if (state_q == PLAY && round_valid) begin
            played_d = played_nxt;
            wins1_d  = wins1_nxt;
            wins2_d  = wins2_nxt;
            if (round_res == MANCHE_TIE) begin
                restr_valid_d = 1'b0;
            end else begin
                restr_valid_d = 1'b1;
                restr_p2_d    = (round_res == MANCHE_P2);
                restr_move_d  = (round_res == MANCHE_P2) ? SECONDO : PRIMO;
            end
            if (match_end) begin
                state_d = IDLE;
            end
        end
    end

    always_comb begin
        manche_d  = MANCHE_NONE;
        partita_d = PARTITA_NONE;
        if (!INIZIO && state_q == PLAY && round_valid) begin
            manche_d = round_res;
            if (match_end) begin
                if (wins1_nxt > wins2_nxt) begin
                    partita_d = PARTITA_P1;
                end else if (wins2_nxt > wins1_nxt) begin
                    partita_d = PARTITA_P2;
                end else begin
                    partita_d = PARTITA_DRAW;
                end
            end
        end
    end

    assign MANCHE  = manche_q;
    assign PARTITA = partita_q;

endmodule

// File: tb/tb_morra_cinese.sv
// Directed bench for the referee: each vector packs {INIZIO, PRIMO, SECONDO,
// expected MANCHE, expected PARTITA}, results sampled 1 ns after the edge.
module tb_morra_cinese;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       INIZIO = 1'b0;
    logic [1:0] PRIMO = 2'b00;
    logic [1:0] SECONDO = 2'b00;
    logic [1:0] MANCHE;
    logic [1:0] PARTITA;

    int checks = 0;
    int errors = 0;

    morra_cinese dut (
        .clk     (clk),
        .rst     (rst),
        .INIZIO  (INIZIO),
        .PRIMO   (PRIMO),
        .SECONDO (SECONDO),
        .MANCHE  (MANCHE),
        .PARTITA (PARTITA)
    );

    always #5 clk = ~clk;

    task automatic step(input logic ini, input logic [1:0] p1, input logic [1:0] p2);
        @(negedge clk);
        INIZIO  = ini;
        PRIMO   = p1;
        SECONDO = p2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (MANCHE !== 2'b00) begin
            errors++;
            $display("FAIL reset MANCHE got %b exp 00", MANCHE);
        end
        checks++;
        if (PARTITA !== 2'b00) begin
            errors++;
            $display("FAIL reset PARTITA got %b exp 00", PARTITA);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 2'b10, 2'b01);
        checks++;
        if ({MANCHE, PARTITA} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_ignore got %b/%b exp 00/00", MANCHE, PARTITA);
        end
        $display("test_reset done");
    endtask

    task automatic test_restriction();
        logic [8:0] v [7];
        v = '{9'b1_00_00_00_00, 9'b0_10_01_01_00, 9'b0_01_10_10_00,
              9'b0_10_00_00_00, 9'b0_11_10_00_00, 9'b0_10_01_01_00,
              9'b0_11_01_10_11};
        for (int i = 0; i < 7; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL restriction vec %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("restriction vec %0d: P1=%b P2=%b -> %b/%b", i, v[i][7:6], v[i][5:4], MANCHE, PARTITA);
        end
    endtask

    task automatic test_ties();
        logic [8:0] v [6];
        v = '{9'b1_00_00_00_00, 9'b0_01_01_11_00, 9'b0_01_01_11_00,
              9'b0_01_01_11_00, 9'b0_01_01_11_11, 9'b0_01_01_00_00};
        for (int i = 0; i < 6; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL ties vec %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("ties vec %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
    endtask

    task automatic test_limit19();
        logic [8:0] v [9];
        logic [3:0] exp_v;
        v = '{9'b1_11_11_00_00,
              9'b0_10_01_01_00, 9'b0_01_10_10_00, 9'b0_01_11_01_00, 9'b0_10_11_10_00,
              9'b0_10_01_01_00, 9'b0_01_10_10_00, 9'b0_01_11_01_00, 9'b0_10_11_10_00};
        for (int i = 0; i < 9; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL limit19 alt %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("limit19 alt %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
        // Rounds 9..19 are ties; only round 19 closes the match.
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 2'b01, 2'b01);
            exp_v = (i == 10) ? 4'b1111 : ((i == 11) ? 4'b0000 : 4'b1100);
            checks++;
            if ({MANCHE, PARTITA} !== exp_v) begin
                errors++;
                $display("FAIL limit19 tie %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, exp_v[3:2], exp_v[1:0]);
            end
            $display("limit19 tie %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
    endtask

    task automatic test_early_diff();
        logic [8:0] v [6];
        v = '{9'b1_11_11_00_00, 9'b0_10_01_01_00, 9'b0_01_01_11_00,
              9'b0_10_01_01_00, 9'b0_11_11_11_01, 9'b0_10_01_00_00};
        for (int i = 0; i < 6; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL early_diff vec %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("early_diff vec %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
    endtask

    task automatic test_early_end();
        logic [8:0] v [5];
        v = '{9'b1_01_10_00_00, 9'b0_10_01_01_00, 9'b0_11_10_01_00,
              9'b0_01_11_01_00, 9'b0_10_01_01_01};
        for (int i = 0; i < 5; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL early_end vec %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("early_end vec %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
    endtask

    task automatic test_mid_inizio();
        logic [8:0] v [8];
        v = '{9'b1_01_10_00_00, 9'b0_10_01_01_00, 9'b0_11_10_01_00,
              9'b1_00_01_00_00, 9'b0_11_01_10_00, 9'b0_01_10_10_00,
              9'b0_10_11_10_00, 9'b0_11_01_10_10};
        for (int i = 0; i < 8; i++) begin
            step(v[i][8], v[i][7:6], v[i][5:4]);
            checks++;
            if ({MANCHE, PARTITA} !== v[i][3:0]) begin
                errors++;
                $display("FAIL mid_inizio vec %0d got %b/%b exp %b/%b",
                         i, MANCHE, PARTITA, v[i][3:2], v[i][1:0]);
            end
            $display("mid_inizio vec %0d: -> %b/%b", i, MANCHE, PARTITA);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 2'b00, 2'b00);
        step(1'b0, 2'b10, 2'b01);
        checks++;
        if (MANCHE !== 2'b01) begin
            errors++;
            $display("FAIL reset_mid pre MANCHE got %b exp 01", MANCHE);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({MANCHE, PARTITA} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid async got %b/%b exp 00/00", MANCHE, PARTITA);
        end
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 2'b11, 2'b10);
        checks++;
        if ({MANCHE, PARTITA} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid ignore got %b/%b exp 00/00", MANCHE, PARTITA);
        end
        step(1'b1, 2'b00, 2'b00);
        step(1'b0, 2'b11, 2'b10);
        checks++;
        if ({MANCHE, PARTITA} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid restart got %b/%b exp 01/00", MANCHE, PARTITA);
        end
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_restriction();
        test_ties();
        test_limit19();
        test_early_diff();
        test_early_end();
        test_mid_inizio();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
